// File: rtl/ux607_sram_icb_bank_ctrl.sv
// ux607_sram_icb_bank_ctrl
// ICB slave front-end for NBANK word-interleaved single-port SRAM banks.
// Commands are steered to one bank by the low word-address bits; responses
// return strictly in command order through a response FIFO of depth OUTS.
// Optional macro UX607_SRAM_BANK_OUTREG_EN: banks have registered outputs,
// so read data is sampled one cycle later (extra pipeline stage).
// Assumes AW_LSB >= 1.
module ux607_sram_icb_bank_ctrl #(
    parameter int unsigned NBANK  = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned MW     = 4,
    parameter int unsigned AW     = 32,
    parameter int unsigned AW_LSB = 2,
    parameter int unsigned USR_W  = 3,
    parameter int unsigned OUTS   = 2,
    localparam int unsigned BW    = (NBANK > 1) ? $clog2(NBANK) : 0,
    localparam int unsigned RAW   = AW - AW_LSB - BW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_cmd,
    input  logic                  i_icb_cmd_valid,
    output logic                  i_icb_cmd_ready,
    input  logic                  i_icb_cmd_read,
    input  logic [AW-1:0]         i_icb_cmd_addr,
    input  logic [DW-1:0]         i_icb_cmd_wdata,
    input  logic [MW-1:0]         i_icb_cmd_wmask,
    input  logic [USR_W-1:0]      i_icb_cmd_usr,
    output logic                  i_icb_rsp_valid,
    input  logic                  i_icb_rsp_ready,
    output logic [DW-1:0]         i_icb_rsp_rdata,
    output logic [USR_W-1:0]      i_icb_rsp_usr,
    output logic [NBANK-1:0]      ram_cs,
    output logic [RAW-1:0]        ram_addr,
    output logic [NBANK*MW-1:0]   ram_wem,
    output logic [DW-1:0]         ram_din,
    input  logic [NBANK*DW-1:0]   ram_dout,
    output logic                  sram_ctrl_active
);

    localparam int unsigned BSW = (BW > 0) ? BW : 1;
    localparam int unsigned CW  = $clog2(OUTS + 1);
    localparam int unsigned PW  = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam logic [CW-1:0] OUTS_C = CW'(OUTS);
    localparam logic [PW-1:0] LAST_P = PW'(OUTS - 1);

    logic              cmd_fire;
    logic              rsp_fire;
    logic [BSW-1:0]    cmd_bank;
    logic [CW-1:0]     cnt_q, cnt_d;

    // first pipeline stage: command attributes needed when data returns
    logic              s1_vld_q;
    logic [BSW-1:0]    s1_bank_q;
    logic              s1_read_q;
    logic [USR_W-1:0]  s1_usr_q;

    // capture stage feeding the response FIFO
    logic              cap_vld;
    logic [BSW-1:0]    cap_bank;
    logic              cap_read;
    logic [USR_W-1:0]  cap_usr;
    logic [DW-1:0]     cap_rdata;

    // response FIFO
    logic [DW-1:0]     fifo_rdata_q [OUTS];
    logic [USR_W-1:0]  fifo_usr_q   [OUTS];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;

    logic              unused_addr_lsb;

    generate
        if (BW > 0) begin : g_bank
            assign cmd_bank = i_icb_cmd_addr[AW_LSB+BW-1:AW_LSB];
        end else begin : g_nobank
            assign cmd_bank = '0;
        end
    endgenerate

    assign unused_addr_lsb = ^i_icb_cmd_addr[AW_LSB-1:0];

    assign ram_addr        = i_icb_cmd_addr[AW-1:AW_LSB+BW];
    assign ram_din         = i_icb_cmd_wdata;
    assign i_icb_cmd_ready = ~stall_cmd & (cnt_q < OUTS_C);
    assign cmd_fire        = i_icb_cmd_valid & i_icb_cmd_ready;
    assign rsp_fire        = i_icb_rsp_valid & i_icb_rsp_ready;

    assign sram_ctrl_active = i_icb_cmd_valid | (cnt_q != '0);

    // chip select and write mask are asserted only for the addressed bank in the fire cycle
    always_comb begin
        ram_cs  = '0;
        ram_wem = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (cmd_fire && (cmd_bank == BSW'(i))) begin
                ram_cs[i] = 1'b1;
                if (!i_icb_cmd_read) begin
                    ram_wem[i*MW +: MW] = i_icb_cmd_wmask;
                end
            end
        end
    end

    // outstanding-command counter next state
    always_comb begin
        cnt_d = cnt_q;
        case ({cmd_fire, rsp_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // outstanding-command counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // stage 1: remember bank, direction and tag of the command that fired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_bank_q <= '0;
            s1_read_q <= 1'b0;
            s1_usr_q  <= '0;
        end else begin
            s1_vld_q  <= cmd_fire;
            s1_bank_q <= cmd_bank;
            s1_read_q <= i_icb_cmd_read;
            s1_usr_q  <= i_icb_cmd_usr;
        end
    end

`ifdef UX607_SRAM_BANK_OUTREG_EN
    logic              s2_vld_q;
    logic [BSW-1:0]    s2_bank_q;
    logic              s2_read_q;
    logic [USR_W-1:0]  s2_usr_q;

    // stage 2: extra delay matching the bank output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_bank_q <= '0;
            s2_read_q <= 1'b0;
            s2_usr_q  <= '0;
        end else begin
            s2_vld_q  <= s1_vld_q;
            s2_bank_q <= s1_bank_q;
            s2_read_q <= s1_read_q;
            s2_usr_q  <= s1_usr_q;
        end
    end

    assign cap_vld  = s2_vld_q;
    assign cap_bank = s2_bank_q;
    assign cap_read = s2_read_q;
    assign cap_usr  = s2_usr_q;
`else
    assign cap_vld  = s1_vld_q;
    assign cap_bank = s1_bank_q;
    assign cap_read = s1_read_q;
    assign cap_usr  = s1_usr_q;
`endif

    // select read data of the registered bank; writes respond with zero data
    always_comb begin
        cap_rdata = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (cap_read && (cap_bank == BSW'(i))) begin
                cap_rdata = ram_dout[i*DW +: DW];
            end
        end
    end

    // FIFO pointer and occupancy next state; push and pop may coincide
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        if (cap_vld) begin
            wptr_d = (wptr_q == LAST_P) ? '0 : wptr_q + 1'b1;
        end
        if (rsp_fire) begin
            rptr_d = (rptr_q == LAST_P) ? '0 : rptr_q + 1'b1;
        end
        case ({cap_vld, rsp_fire})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    // FIFO pointers, occupancy and entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            for (int unsigned i = 0; i < OUTS; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_usr_q[i]   <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
            if (cap_vld) begin
                fifo_rdata_q[wptr_q] <= cap_rdata;
                fifo_usr_q[wptr_q]   <= cap_usr;
            end
        end
    end

    assign i_icb_rsp_valid = (fcnt_q != '0);
    assign i_icb_rsp_rdata = fifo_rdata_q[rptr_q];
    assign i_icb_rsp_usr   = fifo_usr_q[rptr_q];

endmodule

// File: tb/tb_ux607_sram_icb_bank_ctrl.sv
// Scoreboard bench for ux607_sram_icb_bank_ctrl with a two-bank SRAM model.
module tb_ux607_sram_icb_bank_ctrl;

`ifdef UX607_SRAM_BANK_OUTREG_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_cmd = 1'b0;
    logic        i_icb_cmd_valid = 1'b0;
    logic        i_icb_cmd_ready;
    logic        i_icb_cmd_read = 1'b0;
    logic [31:0] i_icb_cmd_addr = '0;
    logic [31:0] i_icb_cmd_wdata = '0;
    logic [3:0]  i_icb_cmd_wmask = '0;
    logic [2:0]  i_icb_cmd_usr = '0;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready = 1'b0;
    logic [31:0] i_icb_rsp_rdata;
    logic [2:0]  i_icb_rsp_usr;
    logic [1:0]  ram_cs;
    logic [28:0] ram_addr;
    logic [7:0]  ram_wem;
    logic [31:0] ram_din;
    logic [63:0] ram_dout;
    logic        sram_ctrl_active;

    ux607_sram_icb_bank_ctrl #(.NBANK(2), .DW(32), .MW(4), .AW(32), .AW_LSB(2), .USR_W(3), .OUTS(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_cmd        (stall_cmd),
        .i_icb_cmd_valid  (i_icb_cmd_valid),
        .i_icb_cmd_ready  (i_icb_cmd_ready),
        .i_icb_cmd_read   (i_icb_cmd_read),
        .i_icb_cmd_addr   (i_icb_cmd_addr),
        .i_icb_cmd_wdata  (i_icb_cmd_wdata),
        .i_icb_cmd_wmask  (i_icb_cmd_wmask),
        .i_icb_cmd_usr    (i_icb_cmd_usr),
        .i_icb_rsp_valid  (i_icb_rsp_valid),
        .i_icb_rsp_ready  (i_icb_rsp_ready),
        .i_icb_rsp_rdata  (i_icb_rsp_rdata),
        .i_icb_rsp_usr    (i_icb_rsp_usr),
        .ram_cs           (ram_cs),
        .ram_addr         (ram_addr),
        .ram_wem          (ram_wem),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout),
        .sram_ctrl_active (sram_ctrl_active)
    );

    always #5 clk = ~clk;

    // SRAM model: bank b word w initialised to 0x11110000*(b+1)+w
    logic [31:0] mem [2][16];
    logic [31:0] dout_r [2];
    initial begin
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 16; w++)
                mem[b][w] = 32'h1111_0000 * (b + 1) + w;
        dout_r[0] = '0;
        dout_r[1] = '0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (ram_cs[b]) begin
                dout_r[b] <= mem[b][ram_addr[3:0]];
                for (int k = 0; k < 4; k++)
                    if (ram_wem[b*4+k]) mem[b][ram_addr[3:0]][8*k +: 8] <= ram_din[8*k +: 8];
            end
        end
    end
`ifdef UX607_SRAM_BANK_OUTREG_EN
    logic [31:0] dout_o [2];
    initial begin dout_o[0] = '0; dout_o[1] = '0; end
    always @(posedge clk) begin
        dout_o[0] <= dout_r[0];
        dout_o[1] <= dout_r[1];
    end
    assign ram_dout = {dout_o[1], dout_o[0]};
`else
    assign ram_dout = {dout_r[1], dout_r[0]};
`endif

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  usr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every response handshake is checked against the head of the queue
    always @(negedge clk) begin
        if (!rst && i_icb_rsp_valid && i_icb_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got usr %0d rdata 0x%0h with nothing expected", i_icb_rsp_usr, i_icb_rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", 64'(i_icb_rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_usr", 64'(i_icb_rsp_usr), 64'(mon_e.usr));
            end
        end
    end

    // issue one command, wait (bounded) for acceptance, check SRAM side, push expectation
    task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [2:0] usr, input logic [1:0] exp_cs,
                        input logic [7:0] exp_wem, input logic [31:0] exp_rdata,
                        output int unsigned waits);
        waits = 0;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read  = rd;
        i_icb_cmd_addr  = addr;
        i_icb_cmd_wdata = wd;
        i_icb_cmd_wmask = wm;
        i_icb_cmd_usr   = usr;
        @(negedge clk);
        while (!i_icb_cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!i_icb_cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready 0 expected 1 for addr 0x%0h", addr);
        end else begin
            chk("ram_cs", 64'(ram_cs), 64'(exp_cs));
            chk("ram_wem", 64'(ram_wem), 64'(exp_wem));
            chk("ram_addr", 64'(ram_addr), 64'(addr >> 3));
            if (!rd) chk("ram_din", 64'(ram_din), 64'(wd));
            exp_q.push_back('{rdata: exp_rdata, usr: usr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_wmask = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        int unsigned lat;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        chk("rst_ram_cs", 64'(ram_cs), 64'd0);
        chk("rst_ram_wem", 64'(ram_wem), 64'd0);
        chk("rst_active", 64'(sram_ctrl_active), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // stall_cmd blocks acceptance
        stall_cmd = 1'b1;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read = 1'b1;
        i_icb_cmd_addr = 32'h0;
        @(negedge clk);
        chk("stall_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
        chk("stall_ram_cs", 64'(ram_cs), 64'd0);
        chk("stall_active", 64'(sram_ctrl_active), 64'd1);
        @(posedge clk);
        #1;
        stall_cmd = 1'b0;
        idle();

        // single read latency
        i_icb_rsp_ready = 1'b0;
        send(1'b1, 32'h0, '0, '0, 3'd7, 2'b01, 8'h00, 32'h1111_0000, w);
        idle();
        lat = 1;
        @(negedge clk);
        while (!i_icb_rsp_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        chk("rsp_latency", 64'(lat), 64'(LAT));
        @(posedge clk);
        #1;
        i_icb_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // back-to-back reads alternate banks, responses in order
        send(1'b1, 32'h0, '0, '0, 3'd1, 2'b01, 8'h00, 32'h1111_0000, w);
        send(1'b1, 32'h4, '0, '0, 3'd2, 2'b10, 8'h00, 32'h2222_0000, w);
        send(1'b1, 32'h8, '0, '0, 3'd3, 2'b01, 8'h00, 32'h1111_0001, w);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("drain_reads", 64'(exp_q.size()), 64'd0);

        // masked write to bank 1 then read back merged word
        send(1'b0, 32'h4, 32'hA5A5_A5A5, 4'h3, 3'd5, 2'b10, 8'h30, 32'h0, w);
        send(1'b1, 32'h4, '0, '0, 3'd0, 2'b10, 8'h00, 32'h2222_A5A5, w);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("drain_write", 64'(exp_q.size()), 64'd0);

        // full FIFO: backpressure, hold, then pop concurrent with a new command
        i_icb_rsp_ready = 1'b0;
        send(1'b1, 32'hC, '0, '0, 3'd4, 2'b10, 8'h00, 32'h2222_0001, w);
        send(1'b1, 32'h8, '0, '0, 3'd5, 2'b01, 8'h00, 32'h1111_0001, w);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read = 1'b1;
        i_icb_cmd_addr = 32'h0;
        i_icb_cmd_usr = 3'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
            chk("hold_rsp_rdata", 64'(i_icb_rsp_rdata), 64'h2222_0001);
            chk("hold_rsp_usr", 64'(i_icb_rsp_usr), 64'd4);
        end
        @(posedge clk);
        #1;
        i_icb_rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop_cycle_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_pop_cmd_ready", 64'(i_icb_cmd_ready), 64'd1);
        chk("after_pop_ram_cs", 64'(ram_cs), 64'h1);
        if (i_icb_cmd_ready) exp_q.push_back('{rdata: 32'h1111_0000, usr: 3'd6});
        @(posedge clk);
        #1;
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("drain_full", 64'(exp_q.size()), 64'd0);

        // reset with two responses pending
        i_icb_rsp_ready = 1'b0;
        send(1'b1, 32'h0, '0, '0, 3'd1, 2'b01, 8'h00, 32'h1111_0000, w);
        send(1'b1, 32'h4, '0, '0, 3'd2, 2'b10, 8'h00, 32'h2222_A5A5, w);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_rsp_valid", 64'(i_icb_rsp_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        chk("async_rst_active", 64'(sram_ctrl_active), 64'd0);
        chk("async_rst_cmd_ready", 64'(i_icb_cmd_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_icb_rsp_ready = 1'b1;
        send(1'b1, 32'h10, '0, '0, 3'd3, 2'b01, 8'h00, 32'h1111_0002, w);
        chk("first_cmd_after_rst_waits", 64'(w), 64'd0);
        idle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_after_rst", 64'(exp_q.size()), 64'd0);
        chk("idle_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
